// File: rtl/mobius_stream_buffer.sv
// Stream front/back end for a combinational Mobius transform core: packs W-bit words
// into an N-bit truth table, waits out the core latency, then unpacks the ANF result.
module mobius_stream_buffer #(
  parameter int N   = 1024,
  parameter int W   = 32,
  parameter int LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [N-1:0] tt_out,
  output logic         tt_valid,
  input  logic [N-1:0] anf_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);
  localparam int WORDS = N / W;
  localparam int CW    = $clog2(WORDS);
  localparam int LW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] WLAST = CW'(WORDS - 1);
  localparam logic [LW-1:0] LLAST = LW'(LAT);

  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] wcnt;
  logic [LW-1:0] lcnt;
  logic [N-1:0]  anf_q;
  logic          in_fire, out_fire, last_word, last_lat;

  assign in_fire   = in_valid  && (state == LOAD);
  assign out_fire  = out_ready && (state == DRAIN);
  assign last_word = (wcnt == WLAST);
  assign last_lat  = (lcnt == LLAST);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    tt_valid  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_fire && last_word) state_nx = WAIT;
      end
      WAIT: begin
        tt_valid = 1'b1;
        if (last_lat) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && last_word) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Output word is gated so the port idles at zero outside DRAIN.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) out_data = anf_q[int'(wcnt)*W +: W];
  end

  // One counter serves both phases; they never overlap, so it is always zero on entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt   <= '0;
      lcnt   <= '0;
      tt_out <= '0;
      anf_q  <= '0;
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          tt_out[int'(wcnt)*W +: W] <= in_data;
          wcnt <= last_word ? '0 : wcnt + CW'(1);
        end
        WAIT: begin
          if (last_lat) begin
            anf_q <= anf_in;
            lcnt  <= '0;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        DRAIN: if (out_fire) wcnt <= last_word ? '0 : wcnt + CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mobius_stream_buffer.sv
// Directed bench: two buffers (LAT=0 and LAT=2, N=8, W=2) wrapped around a software
// Mobius core; bit i of every truth table / ANF vector is index i.
module tb_mobius_stream_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv[2], ir[2], tv[2], ov[2], ordy[2], bz[2];
  logic [1:0] id[2], od[2];
  logic [7:0] tt[2], anf[2];
  logic [7:0] p1, p2;
  logic       corrupt;
  int n_run = 0, n_fail = 0;

  function automatic logic [7:0] mob(input logic [7:0] t);
    logic [7:0] r = '0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++)
        if ((v & ~u) == 0) r[u] = r[u] ^ t[v];
    return r;
  endfunction

  // anf_in is scrambled while draining, so only the capture-edge sample may matter.
  assign anf[0] = mob(tt[0]) ^ {8{corrupt}};
  assign anf[1] = p2 ^ {8{corrupt}};
  always_ff @(posedge clk) begin
    p1 <= mob(tt[1]);
    p2 <= p1;
  end

  mobius_stream_buffer #(.N(8), .W(2), .LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .tt_out(tt[0]), .tt_valid(tv[0]), .anf_in(anf[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));

  mobius_stream_buffer #(.N(8), .W(2), .LAT(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .tt_out(tt[1]), .tt_valid(tv[1]), .anf_in(anf[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int d, input logic [7:0] v, input int gap);
    for (int k = 0; k < 4; k++) begin
      iv[d] = 1'b0;
      if (gap > 0) repeat ($urandom_range(gap, 0)) tick();
      iv[d] = 1'b1;
      id[d] = v[2*k +: 2];
      tick();
    end
    iv[d] = 1'b0;
  endtask

  task automatic drain(input int d, input int stall_k, output logic [7:0] got);
    got = '0;
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      ordy[d] = 1'b0;
      while (ov[d] !== 1'b1 && t < 30) begin tick(); t++; end
      chk("drain_valid", 32'(ov[d]), 32'd1);
      corrupt = 1'b1;
      repeat ($urandom_range(2, 0)) tick();
      if (k == stall_k) begin
        logic [1:0] held = od[d];
        repeat (5) begin
          tick();
          chk("stall_hold", {ov[d], ir[d], od[d]}, {1'b1, 1'b0, held});
        end
      end
      got[2*k +: 2] = od[d];
      ordy[d] = 1'b1;
      tick();
    end
    ordy[d] = 1'b0;
    corrupt = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] got, v;
    int t;
    rst = 1'b1; corrupt = 1'b0;
    for (int d = 0; d < 2; d++) begin iv[d] = 1'b0; ordy[d] = 1'b0; id[d] = '0; end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 32'(ir[d]), 32'd1);
      chk("rst_tt_out",   32'(tt[d]), 32'd0);
      chk("rst_tt_valid", 32'(tv[d]), 32'd0);
      chk("rst_out_valid",32'(ov[d]), 32'd0);
      chk("rst_out_data", 32'(od[d]), 32'd0);
      chk("rst_busy",     32'(bz[d]), 32'd0);
    end
    rst = 1'b0;

    // T1: all-ones table, LAT=0 timing
    send(0, 8'hFF, 0);
    chk("t1_c1", {tv[0], ir[0], ov[0], bz[0]}, 4'b1001);
    chk("t1_tt", 32'(tt[0]), 32'hFF);
    tick();
    chk("t1_c2_valid", {tv[0], ir[0], ov[0]}, 3'b001);
    drain(0, -1, got);
    chk("t1_anf", 32'(got), 32'h01);
    chk("t1_back_load", {ir[0], ov[0], bz[0]}, 3'b100);

    // T2: only index 0 set
    send(0, 8'h01, 0);
    drain(0, -1, got);
    chk("t2_anf", 32'(got), 32'hFF);

    // T3: LAT=2 timing
    send(1, 8'hB4, 0);
    for (int c = 1; c <= 3; c++) begin
      chk("t3_wait", {tv[1], ir[1], ov[1]}, 3'b100);
      tick();
    end
    chk("t3_c4", {tv[1], ir[1], ov[1]}, 3'b001);
    drain(1, 1, got);
    chk("t3_anf", 32'(got), 32'(mob(8'hB4)));
    chk("t3_const", 32'(mob(8'h01)), 32'hFF);

    // T4: random gaps and backpressure
    for (int i = 0; i < 1000; i++) begin
      v = 8'($urandom);
      send(i % 2, v, 3);
      drain(i % 2, (i % 7 == 0) ? (i % 4) : -1, got);
      chk("t4_rand", 32'(got), 32'(mob(v)));
    end

    // T5: reset after two words discards the partial table
    for (int k = 0; k < 2; k++) begin iv[0] = 1'b1; id[0] = 2'(k + 1); tick(); end
    iv[0] = 1'b0;
    do_rst();
    chk("t5_rst", {32'(tt[0])}, 32'd0);
    chk("t5_ready", 32'(ir[0]), 32'd1);
    send(0, 8'h6C, 0);
    chk("t5_tt", 32'(tt[0]), 32'h6C);
    drain(0, -1, got);
    chk("t5_anf", 32'(got), 32'(mob(8'h6C)));

    // T6: reset in DRAIN after word 1
    send(1, 8'h3A, 0);
    t = 0;
    while (ov[1] !== 1'b1 && t < 30) begin tick(); t++; end
    chk("t6_valid", 32'(ov[1]), 32'd1);
    ordy[1] = 1'b1;
    tick(); tick();
    ordy[1] = 1'b0;
    chk("t6_mid_drain", 32'(ov[1]), 32'd1);
    do_rst();
    chk("t6_after_rst", {ov[1], ir[1], bz[1], tv[1]}, 4'b0100);
    send(1, 8'h95, 1);
    drain(1, 2, got);
    chk("t6_anf", 32'(got), 32'(mob(8'h95)));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
